tx_arbiter: RTL and testbench
=============================

Name: tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmitter (Send/Sent/Din four-phase handshake) among NREQ byte requesters.
- Sits between requesting blocks (e.g. command/response formatters) and the tx instance.
- Latches the winner's byte, drives the full Send/Sent handshake, pulses a per-requester Done, then enforces a programmable inter-frame gap.

Parameters:
NREQ, 4, number of requesters; legal range 2..8
GAP_CYCLES, 16, idle clk cycles inserted after each completed frame; 0 = no gap

Ports:
clk  input  1  system clock, rising edge
Reset_n  input  1  asynchronous, active-low reset
Req  input  NREQ  level request per requester; bit i = requester i
Din_req  input  NREQ*8  byte per requester; requester i on bits [8i+7:8i]
Grant  output  NREQ  one-hot owner of the transmitter; 0 when none
Done  output  NREQ  one-cycle pulse on bit i when requester i's byte is fully handshaked
Busy  output  1  1 whenever the FSM is not in IDLE
Send  output  1  to tx Send
Din  output  8  to tx Din
Sent  input  1  from tx Sent

Behaviour:
- Reset (Reset_n=0, asynchronous): Send=0, Din=8'h00, Grant=0, Done=0, Busy=0, state=IDLE, rr pointer=0. Releasing reset during a tx frame is legal; the arbiter re-enters IDLE and the gating rule below applies.
- All outputs are registered. Sent and Req are synchronous to clk; no synchronisers.
- States: IDLE, SEND, RELEASE, GAP.
- IDLE:
  - Arbitration is enabled only when Sent==0 and |Req==1.
  - Winner = first asserted Req bit scanning circularly from ptr upward (ptr, ptr+1, ... NREQ-1, 0, ...).
  - On that edge: Grant<=onehot(winner), Din<=Din_req[winner], Send<=1, state->SEND.
  - Latency: Req sampled at edge N gives Grant/Din/Send high after edge N.
  - A stale Sent==1 in IDLE blocks arbitration until Sent==0.
- SEND: hold Send=1, Din, and Grant. On Sent==1: Send<=0, state->RELEASE.
- RELEASE: Send=0. On Sent==0:
  - Done[winner]<=1 for exactly one cycle.
  - Grant<=0.
  - ptr<=(winner+1) mod NREQ.
  - state->GAP if GAP_CYCLES>0, else IDLE.
- GAP: down-counter loaded with GAP_CYCLES-1 on entry, decremented each cycle; at 0, state->IDLE. Counter width is $clog2(GAP_CYCLES+1), minimum 1. Req is ignored during GAP.
- Busy=1 in SEND, RELEASE, GAP.
- Din_req is sampled only at grant. Later changes to Din_req, or withdrawal of Req after grant, do not affect the frame in flight; it completes and Done still pulses.
- If a requester keeps Req high after Done, it is re-eligible, but the advanced ptr gives every other pending requester one turn first.
- Simultaneous requests in the same cycle are resolved by ptr order only. With a single requester, that requester wins every time.
- Sent is never expected high outside SEND/RELEASE, apart from the stale case in IDLE. A Sent glitch in GAP is ignored.
- No priority inversion: between two grants to the same requester, every other continuously pending requester is granted exactly once.

Optional Feature:
- Macro: TX_ARB_FIXED_PRI_EN.
- Defined: ptr is held at 0 permanently, so arbitration is fixed priority (requester 0 highest, NREQ-1 lowest). All other behaviour is unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Single request: after reset, Req=4'b0100, Din_req[23:16]=8'hA5; tx model raises Sent 5 cycles after Send, drops Sent 3 cycles after Send falls. Required: Grant=4'b0100 and Din=8'hA5 one cycle after Req; Send falls the cycle after Sent rises; Done=4'b0100 for one cycle after Sent falls; Busy low exactly 16 cycles later.
- Round-robin: Req=4'b1111 held continuously. Required: grant order 0,1,2,3,0; each frame separated by ≥16 idle cycles; Done pulses in the same order.
- Fairness: Req[0] held high, Req[2] raised during requester 0's first frame. Required: next grant is requester 2, then requester 0. With TX_ARB_FIXED_PRI_EN defined, requester 0 wins repeatedly and requester 2 waits.
- Stale Sent / withdrawal:
  - Sent held 1 in IDLE with Req=4'b0001: no Grant until Sent=0.
  - Req withdrawn and Din_req changed to 8'h00 mid-SEND: Din stays at the original byte, and Done still pulses.
- Async reset mid-frame: assert Reset_n=0 while in SEND. Required: Send, Grant, Busy, and Din go to 0 immediately without a clock edge. After release with Req=4'b0010, grant goes to requester 1 (ptr=0 scan).
- GAP_CYCLES=0 build: back-to-back requests. Required: next Grant appears one cycle after the previous Done pulse.

Source files
------------

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin owner of one UART transmitter.
// Up to NREQ byte requesters share the Send/Sent/Din four-phase handshake.
// The arbiter latches the winner's byte, runs the handshake, pulses Done for
// that requester, then holds off for GAP_CYCLES idle cycles.
// Optional build macro TX_ARB_FIXED_PRI_EN: the round-robin pointer is held
// at 0, which turns the arbiter into fixed priority with requester 0 highest.
module tx_arbiter #(
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic [NREQ-1:0]   Req,
    input  logic [NREQ*8-1:0] Din_req,
    output logic [NREQ-1:0]   Grant,
    output logic [NREQ-1:0]   Done,
    output logic              Busy,
    output logic              Send,
    output logic [7:0]        Din,
    input  logic              Sent
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [PW-1:0]   win, win_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [NREQ-1:0] grant_n, done_n;
    logic            busy_n, send_n;
    logic [7:0]      din_n;
    logic [PW-1:0]   pick;
    logic            found;

    // Circular scan for the first asserted request starting at ptr.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && Req[i] && (i == (int'(ptr) + k) % NREQ)) begin
                    found = 1'b1;
                    pick  = PW'(i);
                end
            end
        end
    end

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        win_n   = win;
        cnt_n   = cnt;
        grant_n = Grant;
        done_n  = '0;
        send_n  = Send;
        din_n   = Din;

        unique case (state)
            IDLE: begin
                // A stale Sent left over from an interrupted frame blocks arbitration.
                if (!Sent && found) begin
                    win_n   = pick;
                    grant_n = '0;
                    for (int i = 0; i < NREQ; i++) begin
                        if (pick == PW'(i)) begin
                            grant_n[i] = 1'b1;
                            din_n      = Din_req[i*8 +: 8];
                        end
                    end
                    send_n  = 1'b1;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (Sent) begin
                    send_n  = 1'b0;
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (!Sent) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (win == PW'(i)) done_n[i] = 1'b1;
                    end
                    grant_n = '0;
                    ptr_n   = (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
                    if (GAP_CYCLES > 0) begin
                        cnt_n   = GAP_LOAD;
                        state_n = GAP;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            GAP: begin
                // Requests and any Sent glitch are ignored while the gap runs out.
                if (cnt == '0) state_n = IDLE;
                else           cnt_n   = cnt - CW'(1);
            end
            default: state_n = IDLE;
        endcase

`ifdef TX_ARB_FIXED_PRI_EN
        ptr_n = '0;
`endif

        busy_n = (state_n != IDLE);
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            ptr   <= '0;
            win   <= '0;
            cnt   <= '0;
            Grant <= '0;
            Done  <= '0;
            Busy  <= 1'b0;
            Send  <= 1'b0;
            Din   <= 8'h00;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            win   <= win_n;
            cnt   <= cnt_n;
            Grant <= grant_n;
            Done  <= done_n;
            Busy  <= busy_n;
            Send  <= send_n;
            Din   <= din_n;
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: directed table, hand sequences and random traffic
// checked by an event-level scoreboard (round-robin pick, byte capture,
// Done ordering, inter-frame gap). A second instance covers GAP_CYCLES=0.
module tb_tx_arbiter;

    localparam int NREQ = 4;
    localparam int GAP  = 16;
`ifdef TX_ARB_FIXED_PRI_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            Reset_n;
    logic [NREQ-1:0] Req, Grant, Done;
    logic [31:0]     Din_req;
    logic            Busy, Send, Sent;
    logic [7:0]      Din;

    logic [NREQ-1:0] Req0, Grant0, Done0;
    logic [31:0]     Din_req0;
    logic            Busy0, Send0, Sent0;
    logic [7:0]      Din0;

    tx_arbiter #(.NREQ(NREQ), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .Reset_n(Reset_n), .Req(Req), .Din_req(Din_req),
        .Grant(Grant), .Done(Done), .Busy(Busy), .Send(Send), .Din(Din), .Sent(Sent)
    );

    tx_arbiter #(.NREQ(NREQ), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .Reset_n(Reset_n), .Req(Req0), .Din_req(Din_req0),
        .Grant(Grant0), .Done(Done0), .Busy(Busy0), .Send(Send0), .Din(Din0), .Sent(Sent0)
    );

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [7:0] lane(input logic [31:0] v, input int i);
        if (i < 0) return 8'h00;
        return v[i*8 +: 8];
    endfunction

    function automatic int oh2i(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] i2oh(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    // Transmitter model: raise Sent up_dly cycles after Send, drop it dn_dly cycles after Send falls.
    bit   tx_auto, rnd_dly;
    logic sent_auto, sent_force;
    int   up_dly = 5, dn_dly = 3, up_cnt = 0, dn_cnt = 0;
    assign Sent = tx_auto ? sent_auto : sent_force;

    always @(negedge clk) begin
        if (!tx_auto || !Reset_n) begin
            sent_auto = 1'b0; up_cnt = 0; dn_cnt = 0;
        end else if (Send && !sent_auto) begin
            up_cnt++;
            if (up_cnt >= up_dly) begin sent_auto = 1'b1; up_cnt = 0; end
        end else if (sent_auto && !Send) begin
            dn_cnt++;
            if (dn_cnt >= dn_dly) begin
                sent_auto = 1'b0; dn_cnt = 0;
                if (rnd_dly) begin
                    up_dly = $urandom_range(1, 6);
                    dn_dly = $urandom_range(1, 4);
                end
            end
        end else begin
            up_cnt = 0; dn_cnt = 0;
        end
    end

    // Scoreboard: predicts each grant from the request set and the rotating
    // priority, and pairs every Done with the oldest outstanding grant.
    int              m_ptr = 0, since = 100000, grants_seen = 0;
    int              q[$];
    logic [NREQ-1:0] pg = '0, pd = '0, r_s;
    logic [31:0]     d_s;

    always @(posedge clk) begin
        int w;
        r_s = Req;
        d_s = Din_req;
        #1;
        if (!Reset_n) begin
            m_ptr = 0; q.delete(); since = 100000; pg = '0; pd = '0;
        end else begin
            if (since < 100000) since++;
            if (Grant != '0 && pg == '0) begin
                w = rr_pick(r_s, m_ptr);
                chk("sb_grant", Grant, i2oh(w));
                chk("sb_din", Din, lane(d_s, w));
                if (since < 100000) chk("sb_gap", since >= GAP + 1, 1);
                q.push_back(w);
                grants_seen++;
            end
            if (Done != '0) begin
                chk("sb_done_width", pd, 0);
                if (q.size() == 0) begin
                    chk("sb_done_orphan", Done, 0);
                end else begin
                    w = q.pop_front();
                    chk("sb_done", Done, i2oh(w));
                    m_ptr = FIXED ? 0 : (w + 1) % NREQ;
                end
                since = 0;
            end
            pg = Grant;
            pd = Done;
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        Reset_n = 1'b0;
        tick;
        Reset_n = 1'b1;
        tick;
    endtask

    task automatic wait_grant(input logic [NREQ-1:0] eg, input logic [7:0] ed,
                              input bit exact, input string nm);
        int n;
        n = 0;
        do begin tick; n++; end while (Grant == '0 && n < 60);
        if (exact) chk({nm, "_latency"}, n, 1);
        chk({nm, "_grant"}, Grant, eg);
        chk({nm, "_din"}, Din, ed);
        chk({nm, "_send"}, Send, 1);
        chk({nm, "_busy"}, Busy, 1);
    endtask

    task automatic finish_frame(input logic [NREQ-1:0] eg, input string nm);
        int n;
        n = 0;
        while (!Sent && n < 20) begin tick; n++; end
        chk({nm, "_sent_seen"}, Sent, 1);
        tick;
        chk({nm, "_send_fall"}, Send, 0);
        n = 0;
        while (Done == '0 && n < 20) begin tick; n++; end
        chk({nm, "_done"}, Done, eg);
        tick;
        chk({nm, "_done_pulse"}, Done, 0);
        n = 1;
        while (Busy && n < 60) begin tick; n++; end
        chk({nm, "_gap_len"}, n, GAP);
    endtask

    typedef struct {
        logic [NREQ-1:0] req;
        logic [31:0]     dv;
        logic [NREQ-1:0] g_rr;
        logic [NREQ-1:0] g_fp;
    } vec_t;

    initial begin
        vec_t tbl[8];
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] seq0[3];
        int gs;

        tbl[0] = '{4'b0100, 32'h44A52211, 4'b0100, 4'b0100};
        tbl[1] = '{4'b1111, 32'hD4C3B2A1, 4'b1000, 4'b0001};
        tbl[2] = '{4'b1111, 32'h5A6B7C8D, 4'b0001, 4'b0001};
        tbl[3] = '{4'b0101, 32'h01020304, 4'b0100, 4'b0001};
        tbl[4] = '{4'b0011, 32'hF0E1D2C3, 4'b0001, 4'b0001};
        tbl[5] = '{4'b0011, 32'h99887766, 4'b0010, 4'b0001};
        tbl[6] = '{4'b1001, 32'h12345678, 4'b1000, 4'b0001};
        tbl[7] = '{4'b0010, 32'hCAFEBABE, 4'b0010, 4'b0010};

        Reset_n = 1'b0; Req = '0; Din_req = '0;
        Req0 = '0; Din_req0 = '0; Sent0 = 1'b0;
        tx_auto = 1'b1; rnd_dly = 1'b0; sent_force = 1'b0;
        repeat (3) tick;
        chk("rst_grant", Grant, 0);
        chk("rst_done", Done, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_send", Send, 0);
        chk("rst_din", Din, 0);
        chk("rst_grant0", Grant0, 0);
        Reset_n = 1'b1;
        tick;

        // Directed table, starting from ptr=0 right after reset.
        for (int i = 0; i < 8; i++) begin
            eg      = FIXED ? tbl[i].g_fp : tbl[i].g_rr;
            Req     = tbl[i].req;
            Din_req = tbl[i].dv;
            wait_grant(eg, lane(tbl[i].dv, oh2i(eg)), 1'b1, $sformatf("tbl%0d", i));
            finish_frame(eg, $sformatf("tbl%0d", i));
        end
        Req = '0;
        tick;

        // Continuous all-request round robin.
        do_reset;
        Req = 4'b1111; Din_req = 32'h40302010;
        for (int i = 0; i < 5; i++) begin
            gs = FIXED ? 0 : i % NREQ;
            wait_grant(i2oh(gs), lane(Din_req, gs), 1'b0, $sformatf("rr%0d", i));
            finish_frame(i2oh(gs), $sformatf("rr%0d", i));
        end
        Req = '0;
        tick;

        // Fairness: requester 2 arrives while requester 0 owns the transmitter.
        do_reset;
        Req = 4'b0001; Din_req = 32'h33221100;
        wait_grant(4'b0001, 8'h00, 1'b1, "fair0");
        Req = 4'b0101;
        finish_frame(4'b0001, "fair0");
        eg = FIXED ? 4'b0001 : 4'b0100;
        wait_grant(eg, FIXED ? 8'h00 : 8'h22, 1'b0, "fair1");
        finish_frame(eg, "fair1");
        wait_grant(4'b0001, 8'h00, 1'b0, "fair2");
        Req = '0;
        finish_frame(4'b0001, "fair2");

        // Stale Sent blocks arbitration; withdrawal and byte change mid-frame.
        do_reset;
        tx_auto = 1'b0; sent_force = 1'b1;
        Req = 4'b0001; Din_req = 32'h0000005C;
        repeat (6) tick;
        chk("stale_no_grant", Grant, 0);
        chk("stale_idle", Busy, 0);
        sent_force = 1'b0;
        tick;
        chk("stale_grant", Grant, 4'b0001);
        chk("stale_din", Din, 8'h5C);
        Req = '0; Din_req = '0;
        repeat (2) tick;
        chk("withdraw_din_hold", Din, 8'h5C);
        chk("withdraw_grant_hold", Grant, 4'b0001);
        chk("withdraw_send_hold", Send, 1);
        sent_force = 1'b1;
        tick;
        chk("withdraw_send_fall", Send, 0);
        sent_force = 1'b0;
        tick;
        chk("withdraw_done", Done, 4'b0001);
        for (int n = 0; n < 60 && Busy; n++) tick;
        chk("withdraw_idle", Busy, 0);
        tx_auto = 1'b1;

        // Asynchronous reset in the middle of a frame.
        do_reset;
        Req = 4'b0100; Din_req = 32'h00A50000;
        wait_grant(4'b0100, 8'hA5, 1'b1, "arst_pre");
        tick;
        Reset_n = 1'b0;
        #1;
        chk("arst_send", Send, 0);
        chk("arst_grant", Grant, 0);
        chk("arst_busy", Busy, 0);
        chk("arst_din", Din, 0);
        tick;
        Req = 4'b0010; Din_req = 32'h00007700; Reset_n = 1'b1;
        wait_grant(4'b0010, 8'h77, 1'b1, "arst_post");
        Req = '0;
        finish_frame(4'b0010, "arst_post");

        // Zero-gap instance: back-to-back frames, grant one cycle after Done.
        seq0[0] = 4'b0001;
        seq0[1] = FIXED ? 4'b0001 : 4'b0010;
        seq0[2] = 4'b0001;
        Req0 = 4'b0011; Din_req0 = 32'h0000BBAA;
        tick;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("gap0_grant%0d", i), Grant0, seq0[i]);
            chk($sformatf("gap0_din%0d", i), Din0, lane(Din_req0, oh2i(seq0[i])));
            Sent0 = 1'b1;
            tick;
            chk($sformatf("gap0_send_fall%0d", i), Send0, 0);
            Sent0 = 1'b0;
            tick;
            chk($sformatf("gap0_done%0d", i), Done0, seq0[i]);
            if (i == 2) Req0 = '0;
            tick;
        end
        chk("gap0_idle", Busy0, 0);

        // Random traffic against the scoreboard.
        do_reset;
        rnd_dly = 1'b1;
        gs = grants_seen;
        for (int c = 0; c < 2500; c++) begin
            tick;
            if ($urandom_range(0, 7) == 0) Req = 4'($urandom);
            if ($urandom_range(0, 1) == 1) Din_req = $urandom;
        end
        Req = '0;
        for (int n = 0; n < 100 && Busy; n++) tick;
        tick;
        chk("rand_idle", Busy, 0);
        chk("rand_queue_empty", q.size(), 0);
        chk("rand_grants", grants_seen > gs + 20, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
